// File: rtl/slow_fifo_unpacker.sv
// slow_fifo_unpacker: pops 36-bit FIFO words and serialises them into a valid/ready byte stream
module slow_fifo_unpacker #(
  parameter int pCOUNT_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic                    mode_12bit,
  input  logic                    drain,
  input  logic                    fifo_empty,
  output logic                    fifo_rd,
  input  logic [35:0]             fifo_dout,
  output logic                    byte_valid,
  input  logic                    byte_ready,
  output logic [7:0]              byte_data,
  output logic [pCOUNT_WIDTH-1:0] words_read,
  output logic                    idle
);
  typedef enum logic [1:0] {IDLE, LOAD, EMIT, TAIL} state_t;
  state_t      state;
  logic [35:0] hold;
  logic [2:0]  idx;
  logic        phase;
  logic        mode;
  logic [3:0]  carry;
  logic        accept;
  logic        last;
  logic [5:0]  sh;
  // byte selection, handshake and read strobe; reads are gated off in reset, flush, LOAD and TAIL
  always_comb begin
    accept     = byte_valid & byte_ready;
    last       = mode ? (idx == (phase ? 3'd4 : 3'd3)) : (idx == 3'd2);
    sh         = mode ? ((phase ? 6'd32 : 6'd28) - {idx, 3'b000}) : (6'd28 - 6'd12 * {3'b000, idx});
    byte_data  = (state == TAIL) ? {carry, 4'h0} :
                 (mode && phase && idx == 3'd0) ? {carry, hold[35:32]} : 8'(hold >> sh);
    byte_valid = (state == EMIT) || (state == TAIL);
    idle       = (state == IDLE) && !phase;
    fifo_rd    = rst_n && !flush && !fifo_empty &&
                 ((state == IDLE) || (state == EMIT && accept && last));
  end
  // word sequencing: capture on LOAD, step through bytes on accept, track the 12-bit phase and carry nibble
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      hold       <= '0;
      idx        <= '0;
      phase      <= 1'b0;
      mode       <= 1'b0;
      carry      <= '0;
      words_read <= '0;
    end else if (flush) begin
      state      <= IDLE;
      phase      <= 1'b0;
      carry      <= '0;
      words_read <= '0;
    end else begin
      if (fifo_rd && words_read != '1) words_read <= words_read + 1'b1;
      if (state == IDLE && !phase) mode <= mode_12bit;
      case (state)
        IDLE: state <= fifo_rd ? LOAD : (phase && drain && fifo_empty) ? TAIL : IDLE;
        LOAD: begin
          hold  <= fifo_dout;
          idx   <= '0;
          state <= EMIT;
        end
        EMIT: if (accept) begin
          if (!last) idx <= idx + 3'd1;
          else begin
            if (mode) phase <= !phase;
            if (mode && !phase) carry <= hold[3:0];
            state <= fifo_rd ? LOAD : IDLE;
          end
        end
        TAIL: if (accept) begin
          phase <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_slow_fifo_unpacker.sv
// tb_slow_fifo_unpacker: vector table, directed corner sequences and randomized reference-model checks
module tb_slow_fifo_unpacker;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        mode_12bit;
  logic        drain;
  logic        fifo_empty;
  logic        fifo_rd;
  logic [35:0] fifo_dout;
  logic        byte_valid;
  logic        byte_ready;
  logic [7:0]  byte_data;
  logic [31:0] words_read;
  logic        idle;
  logic        fifo_rd4;
  logic        byte_valid4;
  logic [7:0]  byte_data4;
  logic [3:0]  words_read4;
  logic        idle4;

  slow_fifo_unpacker dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .mode_12bit(mode_12bit), .drain(drain),
    .fifo_empty(fifo_empty), .fifo_rd(fifo_rd), .fifo_dout(fifo_dout), .byte_valid(byte_valid),
    .byte_ready(byte_ready), .byte_data(byte_data), .words_read(words_read), .idle(idle)
  );

  slow_fifo_unpacker #(.pCOUNT_WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .mode_12bit(mode_12bit), .drain(drain),
    .fifo_empty(fifo_empty), .fifo_rd(fifo_rd4), .fifo_dout(fifo_dout), .byte_valid(byte_valid4),
    .byte_ready(byte_ready), .byte_data(byte_data4), .words_read(words_read4), .idle(idle4)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          m12;
    int          nw;
    logic [35:0] w0;
    logic [35:0] w1;
    bit          drn;
    int          nb;
    logic [71:0] exp;
    bit          idle_e;
  } vec_t;

  vec_t        vt[6];
  logic [35:0] q[$];
  logic [35:0] wq[$];
  logic [7:0]  got[$];
  logic [7:0]  exp_q[$];
  int          got_cyc[$];
  int          cyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;
  bit          hold_off = 0;
  bit          prev_stall = 0;
  logic [7:0]  prev_bd = '0;

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // one clock: FIFO model (1-cycle read latency), protocol checks, byte capture
  task automatic cycle();
    logic       rd, bv, rdy;
    logic [7:0] bd;
    fifo_empty = (q.size() == 0) || hold_off;
    #1;
    rd = fifo_rd; bv = byte_valid; bd = byte_data; rdy = byte_ready;
    if (fifo_empty) check("rd_while_empty", rd, 0);
    if (flush) check("rd_while_flush", rd, 0);
    if (prev_stall) begin
      check("stall_valid", bv, 1);
      check("stall_data", bd, prev_bd);
    end
    prev_stall = bv && !rdy && !flush;
    prev_bd = bd;
    @(posedge clk);
    #1;
    if (rd) fifo_dout = (q.size() > 0) ? q.pop_front() : 36'h0;
    if (bv && rdy) begin
      got.push_back(bd);
      got_cyc.push_back(cyc);
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_flush();
    flush = 1'b1;
    cycle();
    flush = 1'b0;
  endtask

  // reference: 8-bit keeps the top byte of each 12-bit sample; 12-bit packs word pairs as one 72-bit big-endian value
  task automatic ref_build(input bit m12, input bit drn);
    logic [71:0] p;
    logic [35:0] w;
    exp_q.delete();
    if (!m12) begin
      foreach (wq[i]) begin
        w = wq[i];
        exp_q.push_back(w[35:28]);
        exp_q.push_back(w[23:16]);
        exp_q.push_back(w[11:4]);
      end
    end else begin
      for (int i = 0; i < wq.size(); i += 2) begin
        if (i + 1 < wq.size()) begin
          p = {wq[i], wq[i+1]};
          for (int k = 0; k < 9; k++) exp_q.push_back(p[71-8*k -: 8]);
        end else begin
          w = wq[i];
          for (int k = 0; k < 4; k++) exp_q.push_back(w[35-8*k -: 8]);
          if (drn) exp_q.push_back({w[3:0], 4'h0});
        end
      end
    end
  endtask

  task automatic expect_bytes(input string name, input logic [71:0] exp, input int nb);
    logic [71:0] e;
    e = exp;
    check({name, "_count"}, got.size(), nb);
    for (int k = 0; k < nb && k < got.size(); k++) check({name, "_byte"}, got[k], e[71-8*k -: 8]);
  endtask

  task automatic run_vec(input vec_t v);
    int bpw;
    do_flush();
    mode_12bit = v.m12;
    drain = v.drn;
    byte_ready = 1'b1;
    q.push_back(v.w0);
    if (v.nw == 2) q.push_back(v.w1);
    got.delete();
    got_cyc.delete();
    repeat (30) cycle();
    expect_bytes("vec", v.exp, v.nb);
    check("vec_words_read", words_read, v.nw);
    check("vec_idle", idle, v.idle_e);
    if (v.nw == 2 && got.size() == v.nb) begin
      bpw = v.m12 ? 4 : 3;
      check("vec_back_to_back", got_cyc[1] - got_cyc[0], 1);
      check("vec_bubble", got_cyc[bpw] - got_cyc[bpw-1], 2);
    end
  endtask

  task automatic run_random(input bit m12, input int nwords, input bit drn);
    logic [35:0] w;
    int n;
    do_flush();
    mode_12bit = m12;
    drain = drn;
    wq.delete();
    for (int i = 0; i < nwords; i++) begin
      w = 36'({$urandom(), $urandom()});
      q.push_back(w);
      wq.push_back(w);
    end
    ref_build(m12, drn);
    got.delete();
    got_cyc.delete();
    n = 0;
    while (got.size() < exp_q.size() && n < 30000) begin
      byte_ready = ($urandom_range(0, 2) != 0);
      hold_off = !drn && ($urandom_range(0, 3) == 0);
      cycle();
      n++;
    end
    hold_off = 0;
    byte_ready = 1'b1;
    repeat (3) cycle();
    check("rand_count", got.size(), exp_q.size());
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) check("rand_byte", got[i], exp_q[i]);
    check("rand_words_read", words_read, nwords);
    check("rand_idle", idle, 1);
  endtask

  initial begin
    vt[0] = '{0, 1, 36'hABC123456, 36'h0, 0, 3, 72'hAB1245_000000000000, 1};
    vt[1] = '{1, 2, 36'h123456789, 36'hABCDEF012, 0, 9, 72'h123456789ABCDEF012, 1};
    vt[2] = '{1, 1, 36'h123456789, 36'h0, 1, 5, 72'h1234567890_00000000, 1};
    vt[3] = '{1, 1, 36'h123456789, 36'h0, 0, 4, 72'h12345678_0000000000, 0};
    vt[4] = '{0, 2, 36'hFFFFFFFFF, 36'h000000000, 0, 6, 72'hFFFFFF000000_000000, 1};
    vt[5] = '{1, 2, 36'h000000000, 36'hFFFFFFFFF, 0, 9, 72'h000000000FFFFFFFFF, 1};

    rst_n = 1'b0; flush = 1'b0; mode_12bit = 1'b0; drain = 1'b0;
    fifo_empty = 1'b0; fifo_dout = '0; byte_ready = 1'b1;
    #3;
    check("reset_fifo_rd", fifo_rd, 0);
    check("reset_byte_valid", byte_valid, 0);
    check("reset_byte_data", byte_data, 0);
    check("reset_words_read", words_read, 0);
    check("reset_idle", idle, 1);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vt[i]) run_vec(vt[i]);

    // flush while stalled mid-word in EMIT
    do_flush();
    mode_12bit = 1'b0; drain = 1'b0;
    q.push_back(36'hABC123456);
    byte_ready = 1'b0;
    repeat (3) cycle();
    byte_ready = 1'b1;
    cycle();
    byte_ready = 1'b0;
    cycle();
    do_flush();
    check("flush_emit_valid", byte_valid, 0);
    check("flush_emit_words", words_read, 0);
    check("flush_emit_idle", idle, 1);
    byte_ready = 1'b1;
    q.push_back(36'h123456789);
    got.delete();
    repeat (12) cycle();
    expect_bytes("flush_emit_next", 72'h124578_000000000000, 3);

    // flush in LOAD while in phase 1, then mode change ignored mid-pair
    do_flush();
    mode_12bit = 1'b1;
    q.push_back(36'h123456789);
    got.delete();
    repeat (12) cycle();
    expect_bytes("phase1_prep", 72'h12345678_0000000000, 4);
    check("phase1_idle", idle, 0);
    q.push_back(36'hABCDEF012);
    cycle();
    q.push_back(36'h123456789);
    do_flush();
    check("flush_load_valid", byte_valid, 0);
    check("flush_load_words", words_read, 0);
    check("flush_load_idle", idle, 1);
    got.delete();
    repeat (12) cycle();
    expect_bytes("flush_load_next", 72'h12345678_0000000000, 4);
    mode_12bit = 1'b0;
    q.push_back(36'hABCDEF012);
    got.delete();
    repeat (12) cycle();
    expect_bytes("mode_ignored", 72'h9ABCDEF012_00000000, 5);
    check("mode_ignored_idle", idle, 1);

    run_random(1'b0, 1000, 1'b0);
    run_random(1'b1, 1000, 1'b0);
    run_random(1'b1, 7, 1'b1);

    // saturation of the narrow counter
    do_flush();
    mode_12bit = 1'b0; drain = 1'b0;
    for (int i = 0; i < 20; i++) q.push_back(36'($urandom()));
    repeat (100) cycle();
    check("sat_words_read32", words_read, 20);
    check("sat_words_read4", words_read4, 15);

    // asynchronous reset mid-stream
    for (int i = 0; i < 5; i++) q.push_back(36'hFEDCBA987);
    repeat (6) cycle();
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_fifo_rd", fifo_rd, 0);
    check("async_rst_valid", byte_valid, 0);
    check("async_rst_data", byte_data, 0);
    check("async_rst_words", words_read, 0);
    check("async_rst_words4", words_read4, 0);
    check("async_rst_idle", idle, 1);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    prev_stall = 0;
    run_vec(vt[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/slow_fifo_unpacker.md
Name: slow_fifo_unpacker

Overview:
Drain-side companion to the combined slow FIFO. It pops 36-bit words from the FIFO read port (standard, non-FWFT, 1-cycle read latency) and serialises them into a byte stream for the USB readout path, with valid/ready handshaking. Two packing modes:
- 8-bit: top 8 bits of each of three 12-bit samples per word.
- 12-bit: dense big-endian packing, 9 bytes per 2 words.

Parameters:
pCOUNT_WIDTH, 32, width of words_read counter (saturating).

Ports:
clk  in  1  single clock (FIFO read clock domain)
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous clear of unpacker state and counter
mode_12bit  in  1  0 = 8-bit mode, 1 = 12-bit packed mode
drain  in  1  end of capture; permits emission of a trailing half-word byte
fifo_empty  in  1  FIFO empty flag
fifo_rd  out  1  FIFO read strobe (combinational)
fifo_dout  in  36  FIFO read data, valid the cycle after fifo_rd
byte_valid  out  1  byte_data valid
byte_ready  in  1  downstream accept
byte_data  out  8  output byte
words_read  out  pCOUNT_WIDTH  number of fifo_rd pulses since reset/flush, saturating at all-ones
idle  out  1  high in IDLE with no pending carry nibble

Behaviour:
- Reset values: state = IDLE; byte_valid = 0; byte_data = 0; words_read = 0; phase = 0; carry = 0; idle = 1; latched mode = 0.
- States:
  - IDLE: byte_valid = 0.
    - If !fifo_empty and !flush: fifo_rd = 1, go to LOAD.
    - Else if phase = 1 and drain and fifo_empty: go to TAIL.
  - LOAD: capture fifo_dout into the hold register, index = 0, go to EMIT. fifo_rd = 0.
  - EMIT: byte_valid = 1. Accept = byte_valid & byte_ready.
    - On accept of a non-last byte: index++.
    - On accept of the last byte: toggle phase (12-bit mode only). If !fifo_empty, fifo_rd = 1 and go to LOAD; else go to IDLE.
  - TAIL: byte_valid = 1, byte_data = {carry, 4'h0}. On accept: phase = 0, go to IDLE.
- Byte order in 8-bit mode (3 bytes per word): dout[35:28], dout[23:16], dout[11:4].
- Byte order in 12-bit mode:
  - Phase 0 word (4 bytes): [35:28], [27:20], [19:12], [11:4]; carry = [3:0].
  - Phase 1 word (5 bytes): {carry, [35:32]}, [31:24], [23:16], [15:8], [7:0].
- Mode latching: mode_12bit is latched only in IDLE with phase = 0; it is ignored at all other times.
- Handshake: byte_data is held stable while byte_valid & !byte_ready. byte_valid never drops without an accept, except on flush.
- Throughput: exactly one bubble cycle (the LOAD state) between words when the FIFO is non-empty.
- fifo_rd rules:
  - Never asserted while fifo_empty = 1.
  - Never asserted in LOAD or TAIL.
  - At most one read is outstanding.
- Priority: when data is available, a FIFO read takes priority over TAIL.
- flush: on the next clock the block is in IDLE with phase = 0, carry = 0, byte_valid = 0 and words_read = 0. A word captured during LOAD is discarded. fifo_rd is 0 in any cycle where flush = 1.
- words_read: increments on each fifo_rd pulse and holds at its maximum value.
- rst_n mid-operation: all state clears immediately (asynchronous); no fifo_rd is asserted while rst_n = 0.

Test Plan:
1. 8-bit mode, FIFO holds 36'hABC123456, byte_ready = 1 -> bytes AB, 12, 45; exactly one fifo_rd pulse; words_read = 1; idle = 1 afterwards.
2. 12-bit mode, words 36'h123456789 then 36'hABCDEF012, byte_ready = 1 -> bytes 12 34 56 78 9A BC DE F0 12; one bubble between the 4th and 5th byte; phase returns to 0.
3. 12-bit mode, single word 36'h123456789, then fifo_empty = 1 with drain = 1 -> bytes 12 34 56 78 90; idle = 1 afterwards. Same stimulus with drain = 0 -> 4 bytes only, idle stays 0.
4. Random byte_ready back-pressure over 1000 random words in each mode -> byte stream matches the reference model; byte_data stable while stalled; fifo_rd never asserted with fifo_empty = 1.
5. flush asserted mid-word, in EMIT and in LOAD -> byte_valid = 0 on the next cycle; words_read = 0; the next word is unpacked from byte 0 with phase 0.
6. pCOUNT_WIDTH = 4, 20 words read -> words_read saturates at 15. rst_n pulsed mid-stream -> all outputs return to reset values asynchronously.
